// File: rtl/mult_pkg.sv
// Shared state encoding and default sizing for the shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned W_DEFAULT     = 4;
    localparam int unsigned CNT_W_DEFAULT = $clog2(W_DEFAULT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/start_edge_sync.sv
// Two-flop synchronizer for the push-button start, followed by a rising-edge detector.
module start_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_c
);

    logic sync1;
    logic sync2;
    logic sync2_q;

    // sync1/sync2 resolve metastability; sync2_q remembers the previous synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1   <= async_in;
            sync2   <= sync1;
            sync2_q <= sync2;
        end
    end

    assign rise_c = sync2 & ~sync2_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shift-and-add step per clock, W steps per product.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     q_in,
    input  logic [W-1:0]     r_in,
    output logic [W-1:0]     q_out,
    output logic [W-1:0]     r_out,
    output logic [2*W-1:0]   p_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      PW    = 2 * W;
    localparam int unsigned      CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

    state_t           state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [W-1:0]     mplier;
    logic [CNT_W-1:0] count;
    logic             start_rise_c;
    logic [PW-1:0]    acc_sum_c;

    start_edge_sync u_start_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (start),
        .rise_c   (start_rise_c)
    );

    // Accumulator value after this cycle's conditional add; also the final product on the last step.
    always_comb begin
        acc_sum_c = acc;
        if (mplier[0]) begin
            acc_sum_c = acc + mcand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q_out  <= '0;
            r_out  <= '0;
            p_out  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise_c) begin
                        q_out  <= q_in;
                        r_out  <= r_in;
                        p_out  <= '0;
                        acc    <= '0;
                        mcand  <= PW'(q_in);
                        mplier <= r_in;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // Edges seen while calculating are dropped; the detector only fires once per level change.
                    acc    <= acc_sum_c;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == LAST) begin
                        p_out <= acc_sum_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (W=4): vector table, random and exhaustive products, reset corners.
module tb_shift_add_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] q_in;
    logic [3:0] r_in;
    logic [3:0] q_out;
    logic [3:0] r_out;
    logic [7:0] p_out;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_done = -1;

    shift_add_multiplier #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .q_in  (q_in),
        .r_in  (r_in),
        .q_out (q_out),
        .r_out (r_out),
        .p_out (p_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Consecutive done pulses can never be closer than acceptance + W steps apart.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (last_done >= 0) chk("done_spacing_ge7", int'((cyc - last_done) >= 7), 1);
            last_done = cyc;
        end
    end

    // One operation: start asserted at a negedge before E0, held for 'hold' cycles.
    // Expected timeline: done seen at the 7th negedge sample, busy for exactly 4 samples.
    task automatic run_op(input string nm, input logic [3:0] q, input logic [3:0] r,
                          input int hold, input bit disturb, input logic [7:0] exp_p);
        int         dones   = 0;
        int         busy_n  = 0;
        int         done_at = -1;
        logic [7:0] p_d     = '0;
        logic [3:0] q_d     = '0;
        logic [3:0] r_d     = '0;
        @(negedge clk);
        q_in  = q;
        r_in  = r;
        start = 1'b1;
        for (int s = 1; s <= hold + 12; s++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                dones++;
                if (done_at < 0) begin
                    done_at = s;
                    p_d = p_out;
                    q_d = q_out;
                    r_d = r_out;
                end
            end
            if (s == hold) start = 1'b0;
            if (disturb && s == 4) begin
                q_in  = 4'd2;
                r_in  = 4'd1;
                start = 1'b1;
            end
            if (disturb && s == 5) start = 1'b0;
        end
        chk({nm, "_done_count"}, dones, 1);
        chk({nm, "_latency"}, done_at, 7);
        chk({nm, "_busy_cycles"}, busy_n, 4);
        chk({nm, "_p_out"}, int'(p_d), int'(exp_p));
        chk({nm, "_q_out"}, int'(q_d), int'(q));
        chk({nm, "_r_out"}, int'(r_d), int'(r));
        chk({nm, "_p_hold"}, int'(p_out), int'(exp_p));
    endtask

    typedef struct {
        string      nm;
        logic [3:0] q;
        logic [3:0] r;
        int         hold;
        bit         disturb;
        logic [7:0] exp_p;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int         dones;
        int         busy_n;
        logic [3:0] rq;
        logic [3:0] rr;
        logic [7:0] model_p;

        vecs.push_back('{"max_15x15",    4'd15, 4'd15, 1,  1'b0, 8'd225});
        vecs.push_back('{"zero_r_9x0",   4'd9,  4'd0,  1,  1'b0, 8'd0});
        vecs.push_back('{"zero_q_0x9",   4'd0,  4'd9,  1,  1'b0, 8'd0});
        vecs.push_back('{"disturb_7x3",  4'd7,  4'd3,  1,  1'b1, 8'd21});
        vecs.push_back('{"held_5x6",     4'd5,  4'd6,  20, 1'b0, 8'd30});
        vecs.push_back('{"one_1x1",      4'd1,  4'd1,  1,  1'b0, 8'd1});
        vecs.push_back('{"edge_15x1",    4'd15, 4'd1,  1,  1'b0, 8'd15});
        vecs.push_back('{"alt_10x5",     4'd10, 4'd5,  2,  1'b0, 8'd50});

        rst_n = 1'b0;
        start = 1'b0;
        q_in  = '0;
        r_in  = '0;
        #1;
        chk("reset_q_out", int'(q_out), 0);
        chk("reset_r_out", int'(r_out), 0);
        chk("reset_p_out", int'(p_out), 0);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_done",  int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i].nm, vecs[i].q, vecs[i].r, vecs[i].hold, vecs[i].disturb, vecs[i].exp_p);

        // Reset during the second CALC cycle of 12x11 aborts with no done.
        @(negedge clk);
        q_in  = 4'd12;
        r_in  = 4'd11;
        start = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            if (s == 1) start = 1'b0;
        end
        chk("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_q_out", int'(q_out), 0);
        chk("abort_r_out", int'(r_out), 0);
        chk("abort_p_out", int'(p_out), 0);
        chk("abort_busy",  int'(busy), 0);
        chk("abort_done",  int'(done), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        dones  = 0;
        busy_n = 0;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busy_n++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_no_restart", busy_n, 0);
        run_op("after_abort_12x11", 4'd12, 4'd11, 1, 1'b0, 8'd132);

        // start already high when reset releases: exactly one operation.
        @(negedge clk);
        q_in  = 4'd13;
        r_in  = 4'd3;
        start = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                chk("rst_start_latency", s, 7);
            end
        end
        start = 1'b0;
        chk("rst_start_done_count", dones, 1);
        chk("rst_start_p_out", int'(p_out), 39);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            rq = 4'($urandom_range(0, 15));
            rr = 4'($urandom_range(0, 15));
            model_p = 8'(int'(rq) * int'(rr));
            run_op("random", rq, rr, int'($urandom_range(1, 3)), 1'b0, model_p);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                model_p = 8'(a * b);
                run_op("exhaustive", 4'(a), 4'(b), 1, 1'b0, model_p);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: W, default 4, operand width in bits; product width is 2*W.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  push-button level, active-high, asynchronous to clk.
REQ-005 Port: q_in  input  W  multiplicand, sampled only at start acceptance.
REQ-006 Port: r_in  input  W  multiplier, sampled only at start acceptance.
REQ-007 Port: q_out  output  W  latched multiplicand, binary, feeds the display decoder Q digit pair.
REQ-008 Port: r_out  output  W  latched multiplier, binary, feeds the display decoder R digit pair.
REQ-009 Port: p_out  output  2*W  product, binary, feeds the display decoder P digits.
REQ-010 Port: busy  output  1  high while a multiplication is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when p_out takes a new valid product.

Function
REQ-012 start SHALL pass through a 2-flop synchronizer; acceptance is a rising edge of the synchronized signal (sync2=1, previous sync2=0).
REQ-013 FSM states SHALL be IDLE, CALC; the state is IDLE out of reset.
REQ-014 In IDLE on acceptance: q_out<=q_in, r_out<=r_in, p_out<=0, internal accumulator<=0, mcand<=zero-extended q_in, mplier<=r_in, count<=0, busy<=1, state->CALC.
REQ-015 In CALC each cycle: if mplier[0]=1 then acc<=acc+mcand; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
REQ-016 Arithmetic SHALL be unsigned, 2*W bits wide; (2^W-1)^2 fits without overflow; no carry out is kept.
REQ-017 The CALC cycle with count=W-1 SHALL write p_out<=final accumulator, done<=1, busy<=0, and state->IDLE.
REQ-018 Latency: exactly W CALC cycles after acceptance; with W=4, if start rises before edge E0 then acceptance occurs at E2, busy is high from E2 to E6, and p_out/done are valid after E6.
REQ-019 done SHALL be high for exactly one cycle; in all other cycles it is 0.
REQ-020 Acceptances while busy SHALL be ignored; q_in/r_in changes during CALC SHALL NOT affect the result.
REQ-021 A start held high SHALL trigger exactly one operation; a new operation needs start low for at least 1 synchronized cycle.
REQ-022 Operand 0 (either) SHALL still take W cycles and produce p_out=0 with a done pulse.
REQ-023 q_out, r_out, p_out SHALL hold their values between operations.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, q_out=0, r_out=0, p_out=0, busy=0, done=0, count=0, accumulator=0, synchronizer flops=0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release the block SHALL wait for a fresh start edge.
REQ-026 A start already high at reset release SHALL be accepted once, at the second clock edge after the synchronizer sees it.

Structure
REQ-027 Package mult_pkg SHALL hold the state enum (IDLE, CALC), W default, and the count width constant $clog2(W).
REQ-028 One sub-module, start_edge_sync (2-flop synchronizer plus rising-edge detector, async active-low reset), SHALL be instantiated; the rest is flat.

Verification
REQ-029 q_in=15, r_in=15, start pulse -> busy for 4 cycles, then p_out=225, q_out=15, r_out=15, done for 1 cycle.
REQ-030 q_in=9, r_in=0 -> p_out=0 after 4 CALC cycles, done pulse present.
REQ-031 q_in=7, r_in=3 accepted; during CALC change q_in=2 and pulse start again -> p_out=21, single done, second start ignored.
REQ-032 start held high for 20 cycles with q_in=5, r_in=6 -> exactly one done, p_out=30.
REQ-033 rst_n low at the 2nd CALC cycle of 12x11 -> all outputs 0 at once, no done; next start with 12x11 -> p_out=132.
REQ-034 Exhaustive: all 256 (q_in, r_in) pairs back-to-back -> p_out equals q_in*r_in each time, done spacing is at least 7 cycles.
